dec_ex_core: RTL and testbench
==============================

// Module: dec_ex_core
// PURPOSE
//  Decode + two-stage execute slice of the 5-stage MIPS-like pipeline (DEC, EX1, EX2 merged).
//  Decodes a 32-bit instruction, reads a 32x32 register file, registers controls into E1,
//  executes ALU/shift/branch/multiply in E1, and presents registered results, flags,
//  memory controls and branch redirect at the E2 boundary. HI/LO accumulator lives in EX2.
// PARAMETERS
//  none (datapath fixed at 32 bits, 32 registers)
// PORTS
//  Clock        in   1   rising-edge clock
//  nReset       in   1   reset, asynchronous, active-low
//  Instruction  in   32  instruction in decode stage
//  InstrAddr    in   16  byte address of Instruction (zero-extended to 32 internally)
//  RegWriteIn   in   1   writeback enable from WB
//  RAddrIn      in   5   writeback register
//  RData        in   32  writeback data
//  RegAddr      in   5   debug read address
//  RegData      out  32  debug read data (combinational, reg[RegAddr], r0 reads 0)
//  ALUOut       out  32  E2 result (ALU result, link address or memory address)
//  RAddrOut     out  5   E2 destination register
//  RegWriteOut  out  1   E2 register-write enable
//  MemRead      out  1   E2 load
//  MemWrite     out  1   E2 store
//  StoreData    out  32  E2 rt value for stores
//  BranchTaken  out  1   E2 redirect request
//  BranchAddr   out  32  E2 redirect target
//  C,Z,O,N      out  1   E2 flags: carry, zero, signed overflow, negative
// BEHAVIOUR
//  Reset: regfile, E1 and E2 registers, HI/LO and all outputs = 0 (E2 holds a NOP).
//  Regfile: write at posedge when RegWriteIn && RAddrIn!=0; r0 always 0; read of the
//   address being written returns RData same cycle (write-through bypass).
//  Latency: instruction at decode in cycle n -> outputs valid after 2nd rising edge.
//  No internal forwarding beyond the regfile bypass; the pipeline stalls hazards.
//  R-type (op 0) funct: 20 ADD,21 ADDU,22 SUB,23 SUBU,24 AND,25 OR,26 XOR,27 NOR,
//   2A SLT,2B SLTU,00 SLL,02 SRL,03 SRA (shamt),08 JR,10 MFHI,12 MFLO,18 MULT,19 MULTU.
//  Op 1C funct 00 MADD, 01 MADDU: {HI,LO} += rs*rt (signed/unsigned 64-bit, wraps).
//  I-type op: 08 ADDI,09 ADDIU,0A SLTI (sign-ext imm); 0C ANDI,0D ORI,0E XORI (zero-ext);
//   0F LUI (imm<<16); 23 LW, 2B SW (addr = rs+sext(imm)); 04 BEQ, 05 BNE; 02 J, 03 JAL.
//  Dest: R-type rd; I-type/LW rt; JAL r31. No write for SW, branches, J, JR, MULT*, MADD*.
//  Branch target = PC+4+(sext(imm)<<2); J/JAL = {PC+4[31:28],instr[25:0],2'b00}; JR = rs.
//   J/JAL/JR always taken; JAL ALUOut = PC+4. Not-taken branch: BranchTaken=0.
//  Flags: Z = (result==0); N = result[31]; C = carry/borrow-out of add/sub (0 otherwise);
//   O = signed overflow of ADD/SUB/ADDI only, no trap, result still written.
//  MULT/MULTU/MADD* update HI/LO at the edge moving the op from E1 to E2; MFHI/MFLO in
//   E1 read HI/LO combinationally, so back-to-back MULT;MFHI returns the new value.
//  Undefined opcode/funct = NOP: no reg/mem write, no branch, ALUOut=0.
//  Reset asserted mid-operation clears in-flight E1/E2 ops; no writes complete.
// TESTING
//  ADDI r1,r0,5 via WB write; ADD r3,r1,r2 (r2=7) -> ALUOut=12, RAddrOut=3, RegWriteOut=1, 2 cycles.
//  ADD 0x7FFFFFFF+1 -> ALUOut=0x80000000, O=1,N=1,C=0; SUBU 0-1 -> 0xFFFFFFFF, C=1.
//  BEQ r1,r1,+3 at PC 0x40 -> BranchTaken=1, BranchAddr=0x50; BNE same -> BranchTaken=0.
//  MULT 0xFFFFFFFF*2 then MFHI, MFLO -> 0xFFFFFFFF, 0xFFFFFFFE; MADDU adds to {HI,LO}.
//  SW r2,8(r1) r1=0x100 -> MemWrite=1, ALUOut=0x108, StoreData=r2, RegWriteOut=0.
//  Write r0 then read; JAL at 0x20 -> r31 dest, ALUOut=0x24; nReset mid-stream -> all 0.

Source files
------------

// File: rtl/dec_ex_if.sv
// dec_ex_if: bus between the pipeline and the decode/execute slice.
//   Decode inputs : Instruction, InstrAddr
//   Writeback in  : RegWriteIn, RAddrIn, RData
//   Debug read    : RegAddr (in), RegData (out)
//   E2 outputs    : ALUOut, RAddrOut, RegWriteOut, MemRead, MemWrite,
//                   StoreData, BranchTaken, BranchAddr, C, Z, O, N
// Modport slave is the core side; master is the surrounding pipeline/bench.
interface dec_ex_if;
  logic [31:0] Instruction;
  logic [15:0] InstrAddr;
  logic        RegWriteIn;
  logic [4:0]  RAddrIn;
  logic [31:0] RData;
  logic [4:0]  RegAddr;
  logic [31:0] RegData;
  logic [31:0] ALUOut;
  logic [4:0]  RAddrOut;
  logic        RegWriteOut;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] StoreData;
  logic        BranchTaken;
  logic [31:0] BranchAddr;
  logic        C, Z, O, N;

  modport slave (
    input  Instruction, InstrAddr, RegWriteIn, RAddrIn, RData, RegAddr,
    output RegData, ALUOut, RAddrOut, RegWriteOut, MemRead, MemWrite,
           StoreData, BranchTaken, BranchAddr, C, Z, O, N
  );

  modport master (
    output Instruction, InstrAddr, RegWriteIn, RAddrIn, RData, RegAddr,
    input  RegData, ALUOut, RAddrOut, RegWriteOut, MemRead, MemWrite,
           StoreData, BranchTaken, BranchAddr, C, Z, O, N
  );
endinterface

// File: rtl/dec_ex_core.sv
// dec_ex_core: decode + two-stage execute slice (DEC, EX1, EX2).
//   Clock  : rising-edge clock
//   nReset : asynchronous active-low reset
//   bus    : dec_ex_if.slave (decode inputs, writeback port, debug read,
//            registered E2 results/flags/memory controls/branch redirect)
// DEC reads the register file (write-through bypass) and decodes into an
// operation kind plus operands; E1 executes; E2 holds the registered results.
// HI/LO is updated on the E1->E2 edge and read combinationally by MFHI/MFLO.
module dec_ex_core (
  input  logic     Clock,
  input  logic     nReset,
  dec_ex_if.slave  bus
);

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_JR, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_LW, OP_SW, OP_BEQ, OP_BNE,
    OP_J, OP_JAL
  } opKind_e;

  logic [31:0] regs [32];
  logic [31:0] hi, lo;

  // Decode-stage fields
  logic [5:0]  opc, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rsVal, rtVal, sext, pc4;

  assign opc   = bus.Instruction[31:26];
  assign rs    = bus.Instruction[25:21];
  assign rt    = bus.Instruction[20:16];
  assign rd    = bus.Instruction[15:11];
  assign shamt = bus.Instruction[10:6];
  assign funct = bus.Instruction[5:0];
  assign imm   = bus.Instruction[15:0];
  assign sext  = {{16{imm[15]}}, imm};
  assign pc4   = {16'h0000, bus.InstrAddr} + 32'd4;

  assign rsVal = (rs == '0) ? '0 :
                 (bus.RegWriteIn && bus.RAddrIn == rs) ? bus.RData : regs[rs];
  assign rtVal = (rt == '0) ? '0 :
                 (bus.RegWriteIn && bus.RAddrIn == rt) ? bus.RData : regs[rt];
  assign bus.RegData = (bus.RegAddr == '0) ? '0 :
                 (bus.RegWriteIn && bus.RAddrIn == bus.RegAddr) ? bus.RData : regs[bus.RegAddr];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.RegWriteIn && bus.RAddrIn != '0) begin
      regs[bus.RAddrIn] <= bus.RData;
    end
  end

  // I-type ALU forms reuse the R-type kinds with the immediate as operand B;
  // LUI becomes OR with A=0.
  opKind_e     dOp;
  logic [31:0] dA, dB;
  logic [4:0]  dDest;
  logic        dWr;

  always_comb begin
    dOp = OP_NOP; dA = rsVal; dB = rtVal; dDest = rd; dWr = 1'b0;
    case (opc)
      6'h00: begin
        dWr = 1'b1;
        case (funct)
          6'h20: dOp = OP_ADD;
          6'h21: dOp = OP_ADDU;
          6'h22: dOp = OP_SUB;
          6'h23: dOp = OP_SUBU;
          6'h24: dOp = OP_AND;
          6'h25: dOp = OP_OR;
          6'h26: dOp = OP_XOR;
          6'h27: dOp = OP_NOR;
          6'h2A: dOp = OP_SLT;
          6'h2B: dOp = OP_SLTU;
          6'h00: begin dOp = OP_SLL; dA = rtVal; dB = {27'd0, shamt}; end
          6'h02: begin dOp = OP_SRL; dA = rtVal; dB = {27'd0, shamt}; end
          6'h03: begin dOp = OP_SRA; dA = rtVal; dB = {27'd0, shamt}; end
          6'h08: begin dOp = OP_JR;    dWr = 1'b0; end
          6'h10: dOp = OP_MFHI;
          6'h12: dOp = OP_MFLO;
          6'h18: begin dOp = OP_MULT;  dWr = 1'b0; end
          6'h19: begin dOp = OP_MULTU; dWr = 1'b0; end
          default: dWr = 1'b0;
        endcase
      end
      6'h1C: begin
        if (funct == 6'h00) dOp = OP_MADD;
        else if (funct == 6'h01) dOp = OP_MADDU;
      end
      6'h08: begin dOp = OP_ADD;  dB = sext; dDest = rt; dWr = 1'b1; end
      6'h09: begin dOp = OP_ADDU; dB = sext; dDest = rt; dWr = 1'b1; end
      6'h0A: begin dOp = OP_SLT;  dB = sext; dDest = rt; dWr = 1'b1; end
      6'h0C: begin dOp = OP_AND;  dB = {16'd0, imm}; dDest = rt; dWr = 1'b1; end
      6'h0D: begin dOp = OP_OR;   dB = {16'd0, imm}; dDest = rt; dWr = 1'b1; end
      6'h0E: begin dOp = OP_XOR;  dB = {16'd0, imm}; dDest = rt; dWr = 1'b1; end
      6'h0F: begin dOp = OP_OR; dA = '0; dB = {imm, 16'd0}; dDest = rt; dWr = 1'b1; end
      6'h23: begin dOp = OP_LW;   dB = sext; dDest = rt; dWr = 1'b1; end
      6'h2B: begin dOp = OP_SW;   dB = sext; end
      6'h04: dOp = OP_BEQ;
      6'h05: dOp = OP_BNE;
      6'h02: dOp = OP_J;
      6'h03: begin dOp = OP_JAL; dDest = 5'd31; dWr = 1'b1; end
      default: dOp = OP_NOP;
    endcase
    if (!(dWr && dDest != '0)) begin
      dWr = 1'b0; dDest = '0;
    end
  end

  // E1 registers
  opKind_e     e1Op;
  logic [31:0] e1A, e1B, e1Rt, e1Pc4, e1Imm;
  logic [25:0] e1JIdx;
  logic [4:0]  e1Dest;
  logic        e1Wr;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      e1Op <= OP_NOP; e1A <= '0; e1B <= '0; e1Rt <= '0; e1Pc4 <= '0;
      e1Imm <= '0; e1JIdx <= '0; e1Dest <= '0; e1Wr <= 1'b0;
    end else begin
      e1Op <= dOp; e1A <= dA; e1B <= dB; e1Rt <= rtVal; e1Pc4 <= pc4;
      e1Imm <= sext; e1JIdx <= bus.Instruction[25:0]; e1Dest <= dDest; e1Wr <= dWr;
    end
  end

  // E1 execute
  logic [32:0]        sum, diff;
  logic signed [63:0] sprod;
  logic [63:0]        uprod, hiloNext;
  logic [31:0]        res, ba;
  logic               c, o, mr, mw, bt, hiloWe;

  assign sum   = {1'b0, e1A} + {1'b0, e1B};
  assign diff  = {1'b0, e1A} - {1'b0, e1B};
  assign sprod = $signed(e1A) * $signed(e1B);
  assign uprod = {32'd0, e1A} * {32'd0, e1B};

  always_comb begin
    res = '0; c = 1'b0; o = 1'b0; mr = 1'b0; mw = 1'b0; bt = 1'b0; ba = '0;
    hiloWe = 1'b0; hiloNext = {hi, lo};
    case (e1Op)
      OP_ADD:   begin res = sum[31:0]; c = sum[32];
                      o = (e1A[31] == e1B[31]) && (res[31] != e1A[31]); end
      OP_ADDU:  begin res = sum[31:0]; c = sum[32]; end
      OP_SUB:   begin res = diff[31:0]; c = diff[32];
                      o = (e1A[31] != e1B[31]) && (res[31] != e1A[31]); end
      OP_SUBU:  begin res = diff[31:0]; c = diff[32]; end
      OP_AND:   res = e1A & e1B;
      OP_OR:    res = e1A | e1B;
      OP_XOR:   res = e1A ^ e1B;
      OP_NOR:   res = ~(e1A | e1B);
      OP_SLT:   res = {31'd0, $signed(e1A) < $signed(e1B)};
      OP_SLTU:  res = {31'd0, e1A < e1B};
      OP_SLL:   res = e1A << e1B[4:0];
      OP_SRL:   res = e1A >> e1B[4:0];
      OP_SRA:   res = 32'($signed(e1A) >>> e1B[4:0]);
      OP_JR:    begin bt = 1'b1; ba = e1A; end
      OP_MFHI:  res = hi;
      OP_MFLO:  res = lo;
      OP_MULT:  begin hiloWe = 1'b1; hiloNext = sprod; end
      OP_MULTU: begin hiloWe = 1'b1; hiloNext = uprod; end
      OP_MADD:  begin hiloWe = 1'b1; hiloNext = {hi, lo} + sprod; end
      OP_MADDU: begin hiloWe = 1'b1; hiloNext = {hi, lo} + uprod; end
      OP_LW:    begin res = sum[31:0]; mr = 1'b1; end
      OP_SW:    begin res = sum[31:0]; mw = 1'b1; end
      OP_BEQ:   begin bt = (e1A == e1Rt); ba = e1Pc4 + (e1Imm << 2); end
      OP_BNE:   begin bt = (e1A != e1Rt); ba = e1Pc4 + (e1Imm << 2); end
      OP_J:     begin bt = 1'b1; ba = {e1Pc4[31:28], e1JIdx, 2'b00}; end
      OP_JAL:   begin bt = 1'b1; ba = {e1Pc4[31:28], e1JIdx, 2'b00}; res = e1Pc4; end
      default:  res = '0;
    endcase
  end

  // E2 registers and HI/LO
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      bus.ALUOut <= '0; bus.RAddrOut <= '0; bus.RegWriteOut <= 1'b0;
      bus.MemRead <= 1'b0; bus.MemWrite <= 1'b0; bus.StoreData <= '0;
      bus.BranchTaken <= 1'b0; bus.BranchAddr <= '0;
      bus.C <= 1'b0; bus.Z <= 1'b0; bus.O <= 1'b0; bus.N <= 1'b0;
      hi <= '0; lo <= '0;
    end else begin
      bus.ALUOut <= res; bus.RAddrOut <= e1Dest; bus.RegWriteOut <= e1Wr;
      bus.MemRead <= mr; bus.MemWrite <= mw; bus.StoreData <= e1Rt;
      bus.BranchTaken <= bt; bus.BranchAddr <= bt ? ba : '0;
      bus.C <= c; bus.O <= o; bus.N <= res[31];
      bus.Z <= (e1Op != OP_NOP) && (res == '0);
      if (hiloWe) {hi, lo} <= hiloNext;
    end
  end

endmodule

// File: tb/tb_dec_ex_core.sv
// tb_dec_ex_core: directed-vector bench for dec_ex_core.
module tb_dec_ex_core;
  logic Clock = 1'b0;
  logic nReset;
  int   total = 0;
  int   bad   = 0;

  dec_ex_if bus ();

  dec_ex_core u_dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wbWrite(input logic [4:0] a, input logic [31:0] d);
    @(negedge Clock);
    bus.RegWriteIn = 1'b1; bus.RAddrIn = a; bus.RData = d;
    @(posedge Clock); #1;
    bus.RegWriteIn = 1'b0;
  endtask

  // Issue one instruction followed by a NOP; return #1 after the 2nd edge.
  task automatic runOp(input logic [31:0] instr, input logic [15:0] pc);
    @(negedge Clock);
    bus.Instruction = instr; bus.InstrAddr = pc;
    @(negedge Clock);
    bus.Instruction = '0;
    @(posedge Clock); #1;
  endtask

  initial begin
    nReset = 1'b0;
    bus.Instruction = '0; bus.InstrAddr = '0; bus.RegWriteIn = 1'b0;
    bus.RAddrIn = '0; bus.RData = '0; bus.RegAddr = '0;
    repeat (2) @(posedge Clock); #1;
    chk("rst_aluout", bus.ALUOut, 32'h0);
    chk("rst_regwr",  {31'd0, bus.RegWriteOut}, 32'h0);
    chk("rst_z",      {31'd0, bus.Z}, 32'h0);
    chk("rst_bt",     {31'd0, bus.BranchTaken}, 32'h0);
    @(negedge Clock); nReset = 1'b1;

    wbWrite(5'd2, 32'd7);
    runOp(32'h20010005, 16'h0);                       // ADDI r1,r0,5
    chk("addi_alu", bus.ALUOut, 32'd5);
    chk("addi_rd",  {27'd0, bus.RAddrOut}, 32'd1);
    wbWrite(5'd1, 32'd5);

    runOp(32'h00221820, 16'h0);                       // ADD r3,r1,r2
    chk("add_alu", bus.ALUOut, 32'd12);
    chk("add_rd",  {27'd0, bus.RAddrOut}, 32'd3);
    chk("add_wr",  {31'd0, bus.RegWriteOut}, 32'd1);

    wbWrite(5'd4, 32'h7FFFFFFF);
    wbWrite(5'd5, 32'd1);
    runOp(32'h00853020, 16'h0);                       // ADD r6,r4,r5
    chk("ovf_alu", bus.ALUOut, 32'h80000000);
    chk("ovf_o", {31'd0, bus.O}, 32'd1);
    chk("ovf_n", {31'd0, bus.N}, 32'd1);
    chk("ovf_c", {31'd0, bus.C}, 32'd0);
    chk("ovf_z", {31'd0, bus.Z}, 32'd0);

    runOp(32'h00053823, 16'h0);                       // SUBU r7,r0,r5
    chk("subu_alu", bus.ALUOut, 32'hFFFFFFFF);
    chk("subu_c", {31'd0, bus.C}, 32'd1);
    chk("subu_o", {31'd0, bus.O}, 32'd0);

    runOp(32'h10210003, 16'h0040);                    // BEQ r1,r1,+3
    chk("beq_bt",   {31'd0, bus.BranchTaken}, 32'd1);
    chk("beq_addr", bus.BranchAddr, 32'h50);
    chk("beq_wr",   {31'd0, bus.RegWriteOut}, 32'd0);
    runOp(32'h14210003, 16'h0040);                    // BNE r1,r1,+3
    chk("bne_bt",   {31'd0, bus.BranchTaken}, 32'd0);

    // MULT r8,r9 ; MFHI r10 ; MFLO r11 back to back
    wbWrite(5'd8, 32'hFFFFFFFF);
    wbWrite(5'd9, 32'd2);
    @(negedge Clock); bus.Instruction = 32'h01090018;
    @(negedge Clock); bus.Instruction = 32'h00005010;
    @(negedge Clock); bus.Instruction = 32'h00005812;
    @(posedge Clock); #1;
    chk("mfhi_val", bus.ALUOut, 32'hFFFFFFFF);
    chk("mfhi_rd",  {27'd0, bus.RAddrOut}, 32'd10);
    @(negedge Clock); bus.Instruction = '0;
    @(posedge Clock); #1;
    chk("mflo_val", bus.ALUOut, 32'hFFFFFFFE);

    // MADDU r9,r9: FFFFFFFF_FFFFFFFE + 4 wraps to 0_00000002
    @(negedge Clock); bus.Instruction = 32'h71290001;
    @(negedge Clock); bus.Instruction = 32'h00005010;
    @(negedge Clock); bus.Instruction = 32'h00005812;
    @(posedge Clock); #1;
    chk("maddu_hi", bus.ALUOut, 32'h0);
    @(negedge Clock); bus.Instruction = '0;
    @(posedge Clock); #1;
    chk("maddu_lo", bus.ALUOut, 32'h2);

    wbWrite(5'd1, 32'h100);
    runOp(32'hAC220008, 16'h0);                       // SW r2,8(r1)
    chk("sw_mw",   {31'd0, bus.MemWrite}, 32'd1);
    chk("sw_mr",   {31'd0, bus.MemRead}, 32'd0);
    chk("sw_addr", bus.ALUOut, 32'h108);
    chk("sw_data", bus.StoreData, 32'd7);
    chk("sw_wr",   {31'd0, bus.RegWriteOut}, 32'd0);
    runOp(32'h8C2C0008, 16'h0);                       // LW r12,8(r1)
    chk("lw_mr",   {31'd0, bus.MemRead}, 32'd1);
    chk("lw_rd",   {27'd0, bus.RAddrOut}, 32'd12);

    runOp(32'h3C0E1234, 16'h0);                       // LUI r14,0x1234
    chk("lui_alu", bus.ALUOut, 32'h12340000);

    runOp(32'h0C000010, 16'h0020);                    // JAL 0x40
    chk("jal_alu",  bus.ALUOut, 32'h24);
    chk("jal_rd",   {27'd0, bus.RAddrOut}, 32'd31);
    chk("jal_bt",   {31'd0, bus.BranchTaken}, 32'd1);
    chk("jal_addr", bus.BranchAddr, 32'h40);

    runOp(32'h00200008, 16'h0);                       // JR r1
    chk("jr_addr", bus.BranchAddr, 32'h100);
    chk("jr_wr",   {31'd0, bus.RegWriteOut}, 32'd0);

    runOp(32'hFC000000, 16'h0);                       // undefined opcode
    chk("undef_alu", bus.ALUOut, 32'h0);
    chk("undef_bt",  {31'd0, bus.BranchTaken}, 32'd0);
    chk("undef_wr",  {31'd0, bus.RegWriteOut}, 32'd0);

    wbWrite(5'd0, 32'hDEAD);
    bus.RegAddr = 5'd0; #1;
    chk("r0_read", bus.RegData, 32'h0);
    bus.RegAddr = 5'd1; #1;
    chk("r1_read", bus.RegData, 32'h100);

    @(negedge Clock);
    bus.RegWriteIn = 1'b1; bus.RAddrIn = 5'd13; bus.RData = 32'h55; bus.RegAddr = 5'd13;
    #1;
    chk("bypass", bus.RegData, 32'h55);
    @(posedge Clock); #1;
    bus.RegWriteIn = 1'b0; #1;
    chk("r13_stored", bus.RegData, 32'h55);

    // Reset with an ADD sitting in E2
    @(negedge Clock); bus.Instruction = 32'h00221820;
    @(negedge Clock); bus.Instruction = '0;
    @(posedge Clock); #1;
    chk("pre_rst_alu", bus.ALUOut, 32'h107);
    nReset = 1'b0; #1;
    chk("mid_rst_alu", bus.ALUOut, 32'h0);
    chk("mid_rst_wr",  {31'd0, bus.RegWriteOut}, 32'd0);
    chk("mid_rst_rd",  {27'd0, bus.RAddrOut}, 32'd0);
    bus.RegAddr = 5'd1; #1;
    chk("mid_rst_reg", bus.RegData, 32'h0);
    @(negedge Clock); nReset = 1'b1;
    @(posedge Clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
